// File: rtl/wr_full_ctrl_pkg.sv
// Shared FIFO pointer definitions and Gray/binary conversions for both clock domains.
// Pure functions and constants; no latency and no flow control of their own.
package wr_full_ctrl_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;

    // Operates on a wide word so any pointer width up to 32 bits can share it;
    // callers zero-extend in and size-cast the result back.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wr_full_ctrl_if.sv
// Write-side FIFO control bundle: pointer-stage inputs and registered status outputs.
// Signal group only; the master drives requests/pointers, the slave returns status.
interface wr_full_ctrl_if
    import wr_full_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);
    logic                  Winc;
    logic [ADDR_WIDTH:0]   W_PTR;
    logic [ADDR_WIDTH:0]   R_GRAY_PTR;
    logic                  OVF_CLR;
    logic                  FULL_flag;
    logic                  ALMOST_FULL;
    logic [ADDR_WIDTH:0]   W_GRAY_PTR;
    logic [ADDR_WIDTH:0]   WR_LEVEL;
    logic                  OVERFLOW;

    modport master (
        output Winc, W_PTR, R_GRAY_PTR, OVF_CLR,
        input  FULL_flag, ALMOST_FULL, W_GRAY_PTR, WR_LEVEL, OVERFLOW
    );

    modport slave (
        input  Winc, W_PTR, R_GRAY_PTR, OVF_CLR,
        output FULL_flag, ALMOST_FULL, W_GRAY_PTR, WR_LEVEL, OVERFLOW
    );
endinterface

// File: rtl/wr_full_ctrl_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the clk domain.
// Latency 2 clk edges; no backpressure, samples every cycle.
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q1;

    // Straight flop-to-flop path: nothing may sit between the two stages.
    always_ff @(posedge clk) begin
        if (!RST) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end
endmodule

// File: rtl/wr_full_ctrl.sv
// Write-domain full/almost-full/level/overflow control for an async FIFO.
// Status registered 1 edge after pointer inputs, read pointer seen 3 edges late; FULL_flag is the producer's backpressure.
module wr_full_ctrl
    import wr_full_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
    parameter int AFULL_THRESH = 14
) (
    input  logic          W_CLK,
    input  logic          RST,
    wr_full_ctrl_if.slave wif
);
    localparam int            PW     = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] THRESH = PW'(AFULL_THRESH);

    logic [PW-1:0] rq2;
    logic          wr_en;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          full_next;

    sync_2ff #(.WIDTH(PW)) u_rsync (
        .clk (W_CLK),
        .RST (RST),
        .d   (wif.R_GRAY_PTR),
        .q   (rq2)
    );

    // Full when our next Gray pointer equals the synced read pointer with the
    // top two bits inverted, i.e. exactly one lap ahead.
    always_comb begin
        wr_en      = wif.Winc & ~wif.FULL_flag;
        ptr_next   = wif.W_PTR + PW'(wr_en);
        gray_next  = PW'(bin2gray(32'(ptr_next)));
        rbin       = PW'(gray2bin(32'(rq2)));
        level_next = ptr_next - rbin;
        full_next  = (gray_next == {~rq2[PW-1:PW-2], rq2[PW-3:0]});
    end

    always_ff @(posedge W_CLK) begin
        if (!RST) begin
            wif.FULL_flag   <= 1'b0;
            wif.ALMOST_FULL <= 1'b0;
            wif.W_GRAY_PTR  <= '0;
            wif.WR_LEVEL    <= '0;
            wif.OVERFLOW    <= 1'b0;
        end else begin
            wif.FULL_flag   <= full_next;
            wif.ALMOST_FULL <= (level_next >= THRESH);
            wif.W_GRAY_PTR  <= gray_next;
            wif.WR_LEVEL    <= level_next;
            // A rejected write outranks a simultaneous clear.
            if (wif.Winc & wif.FULL_flag) begin
                wif.OVERFLOW <= 1'b1;
            end else if (wif.OVF_CLR) begin
                wif.OVERFLOW <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wr_full_ctrl.sv
// Directed bench for wr_full_ctrl: reset, fill, overflow, release, wrap, mid-run reset.
module tb_wr_full_ctrl;
    import wr_full_ctrl_pkg::*;

    logic W_CLK;
    logic RST;
    int   checks   = 0;
    int   failures = 0;

    wr_full_ctrl_if #(.ADDR_WIDTH(4)) wif ();

    wr_full_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(14)) dut (
        .W_CLK (W_CLK),
        .RST   (RST),
        .wif   (wif.slave)
    );

    initial W_CLK = 1'b0;
    always #5 W_CLK = ~W_CLK;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one edge and settle outputs before sampling.
    task automatic tick();
        @(posedge W_CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input int full, input int af,
                             input int wg, input int lvl, input int ovf);
        check({tag, ".full"}, int'(wif.FULL_flag), full);
        check({tag, ".afull"}, int'(wif.ALMOST_FULL), af);
        check({tag, ".wgray"}, int'(wif.W_GRAY_PTR), wg);
        check({tag, ".level"}, int'(wif.WR_LEVEL), lvl);
        check({tag, ".ovf"}, int'(wif.OVERFLOW), ovf);
    endtask

    // Hand-computed Gray codes for pointers 1..16
    int gray_tbl [1:16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 24};

    initial begin
        RST            = 1'b0;
        wif.Winc       = 1'b0;
        wif.W_PTR      = 5'd0;
        wif.R_GRAY_PTR = 5'b10101;
        wif.OVF_CLR    = 1'b1;

        tick();
        tick();
        check_all("reset", 0, 0, 0, 0, 0);
        check("reset.rq2", int'(dut.rq2), 0);

        RST            = 1'b1;
        wif.OVF_CLR    = 1'b0;
        wif.R_GRAY_PTR = 5'd0;

        for (int k = 1; k <= 16; k++) begin
            wif.W_PTR = 5'(k - 1);
            wif.Winc  = 1'b1;
            tick();
            check($sformatf("fill%0d.level", k), int'(wif.WR_LEVEL), k);
            check($sformatf("fill%0d.afull", k), int'(wif.ALMOST_FULL), (k >= 14) ? 1 : 0);
            check($sformatf("fill%0d.full", k), int'(wif.FULL_flag), (k == 16) ? 1 : 0);
            check($sformatf("fill%0d.wgray", k), int'(wif.W_GRAY_PTR), gray_tbl[k]);
        end
        check("fill16.wgray_11000", int'(wif.W_GRAY_PTR), 24);

        // Write attempt while full
        wif.W_PTR = 5'd16;
        wif.Winc  = 1'b1;
        tick();
        check_all("ovf_set", 1, 1, 24, 16, 1);

        wif.OVF_CLR = 1'b1;
        tick();
        check("ovf_set_wins", int'(wif.OVERFLOW), 1);

        wif.Winc = 1'b0;
        tick();
        check("ovf_clear", int'(wif.OVERFLOW), 0);
        check("ovf_clear.full", int'(wif.FULL_flag), 1);

        // One read in the other domain: status follows 3 edges later
        wif.OVF_CLR    = 1'b0;
        wif.R_GRAY_PTR = 5'b00001;
        tick();
        check("rel1.full", int'(wif.FULL_flag), 1);
        check("rel1.level", int'(wif.WR_LEVEL), 16);
        tick();
        check("rel2.full", int'(wif.FULL_flag), 1);
        check("rel2.level", int'(wif.WR_LEVEL), 16);
        tick();
        check_all("rel3", 0, 1, 24, 15, 0);

        // Wrap: W_PTR 31, read pointer 17
        wif.W_PTR      = 5'd31;
        wif.R_GRAY_PTR = 5'b11001;
        wif.Winc       = 1'b0;
        tick();
        tick();
        tick();
        check("wrap_pre.level", int'(wif.WR_LEVEL), 14);
        check("wrap_pre.full", int'(wif.FULL_flag), 0);
        wif.Winc = 1'b1;
        tick();
        check_all("wrap", 0, 1, 0, 15, 0);

        // Build full + overflow, then reset mid-run
        wif.Winc       = 1'b0;
        wif.W_PTR      = 5'd15;
        wif.R_GRAY_PTR = 5'd0;
        tick();
        tick();
        tick();
        check("pre_rst.level", int'(wif.WR_LEVEL), 15);
        wif.Winc = 1'b1;
        tick();
        check("pre_rst.full", int'(wif.FULL_flag), 1);
        wif.W_PTR = 5'd16;
        tick();
        check("pre_rst.ovf", int'(wif.OVERFLOW), 1);
        RST = 1'b0;
        tick();
        check_all("mid_rst", 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wr_full_ctrl.md
WR_FULL_CTRL -- requirements
Module: wr_full_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SHALL set the FIFO address width; FIFO depth = 2**ADDR_WIDTH = 16; pointers are ADDR_WIDTH+1 bits (wrap bit + address).
REQ-002 Parameter AFULL_THRESH, default 14, SHALL set the occupancy at or above which ALMOST_FULL asserts; legal range 1..2**ADDR_WIDTH.
REQ-003 W_CLK  input  1  write-domain clock; the only clock; all state on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-low; sampled on the W_CLK rising edge.
REQ-005 Winc  input  1  write request from the producer, same signal driven to the write pointer stage.
REQ-006 W_PTR  input  ADDR_WIDTH+1  current binary write pointer; bit ADDR_WIDTH is the wrap bit; increments only when Winc & ~FULL_flag.
REQ-007 R_GRAY_PTR  input  ADDR_WIDTH+1  Gray-coded read pointer from the read clock domain; asynchronous to W_CLK.
REQ-008 OVF_CLR  input  1  clears the OVERFLOW sticky bit.
REQ-009 FULL_flag  output  1  registered FIFO-full; fed back to the write pointer stage.
REQ-010 ALMOST_FULL  output  1  registered; occupancy >= AFULL_THRESH.
REQ-011 W_GRAY_PTR  output  ADDR_WIDTH+1  registered Gray write pointer, for synchronisation into the read domain.
REQ-012 WR_LEVEL  output  ADDR_WIDTH+1  registered write-side occupancy, 0..16.
REQ-013 OVERFLOW  output  1  sticky; a write was attempted while full.

Function
REQ-014 R_GRAY_PTR SHALL pass through exactly two W_CLK flops (rq1, rq2) before any use; no logic between the flops.
REQ-015 wr_en = Winc & ~FULL_flag; ptr_next = W_PTR + wr_en, modulo 2**(ADDR_WIDTH+1).
REQ-016 gray_next = ptr_next ^ (ptr_next >> 1); W_GRAY_PTR SHALL load gray_next every cycle, so it tracks the pointer stage with zero cycle offset.
REQ-017 FULL_flag SHALL load (gray_next == {~rq2[MSB:MSB-1], rq2[MSB-2:0]}) every cycle; full therefore asserts on the same edge that stores the 16th word, and no write past full is possible.
REQ-018 rbin = Gray-to-binary of rq2; WR_LEVEL SHALL load (ptr_next - rbin) modulo 2**(ADDR_WIDTH+1); wrap of either pointer SHALL yield the correct level.
REQ-019 ALMOST_FULL SHALL load ((ptr_next - rbin) >= AFULL_THRESH); at AFULL_THRESH = 16 it equals FULL_flag.
REQ-020 FULL_flag and WR_LEVEL are pessimistic: they deassert/decrease only 2-3 W_CLK cycles after a read, never early.
REQ-021 OVERFLOW SHALL set on any edge where Winc & FULL_flag; it SHALL clear on OVF_CLR; when set and clear coincide, set wins.
REQ-022 No combinational path from any input to any output.

Reset
REQ-023 With RST = 0 at a W_CLK edge: rq1, rq2, W_GRAY_PTR, WR_LEVEL = 0; FULL_flag, ALMOST_FULL, OVERFLOW = 0; RST overrides all other inputs.
REQ-024 Reset mid-operation (including while full) SHALL return all outputs to reset values on that edge; the pointer stage is reset by the same RST, so no stale full state survives.

Structure
REQ-025 Shared package SHALL hold FIFO_ADDR_WIDTH (4), FIFO_DEPTH (16), and the bin-to-Gray / Gray-to-bin functions, used by both write and read domain blocks.
REQ-026 The two-flop synchroniser SHALL be a separate sub-module, sync_2ff, parameterised by width, reused for the read-side copy.
REQ-027 Full compare, level arithmetic and OVERFLOW reside in wr_full_ctrl.

Verification
REQ-028 Reset: RST = 0 for 2 edges with R_GRAY_PTR = 5'b10101 -> all outputs 0, rq2 = 0.
REQ-029 Fill: R_GRAY_PTR = 0, Winc = 1 for 16 cycles driving W_PTR 0..16 -> WR_LEVEL 1..16, ALMOST_FULL at the 14th-write edge, FULL_flag = 1 and W_GRAY_PTR = 5'b11000 at the 16th-write edge.
REQ-030 Overflow: hold Winc = 1 while full -> W_PTR held at 16, OVERFLOW = 1 next edge; OVF_CLR = 1 with Winc = 1 -> OVERFLOW stays 1; OVF_CLR = 1, Winc = 0 -> 0.
REQ-031 Release: while full, R_GRAY_PTR changes 0 -> 5'b00001 -> FULL_flag = 0 and WR_LEVEL = 15 exactly 3 edges later (2 sync + 1 register).
REQ-032 Wrap: W_PTR = 31, R_GRAY_PTR = Gray(17) = 5'b11001, Winc = 1 -> ptr_next = 0, WR_LEVEL = 15, FULL_flag = 0.
REQ-033 Mid-operation reset: RST = 0 while FULL_flag = 1 and OVERFLOW = 1 -> both 0 on that edge, WR_LEVEL = 0.
